// File: rtl/charge_stage_sequencer_if.sv
// Charge sequencer bus: host-side controls and measurements in, charger controls and status out.
// The sequencer uses the slave modport; the driving side uses master.
interface charge_stage_sequencer_if;
  logic       start;
  logic       stop;
  logic [7:0] battery_level;
  logic [7:0] voltage;
  logic       overcharge_alert;
  logic       fault_clear;
  logic       charge_en;
  logic [1:0] current_sel;
  logic [2:0] state;
  logic       charge_done;
  logic       fault;
  logic [1:0] fault_code;

  modport slave (
    input  start, stop, battery_level, voltage, overcharge_alert, fault_clear,
    output charge_en, current_sel, state, charge_done, fault, fault_code
  );

  modport master (
    output start, stop, battery_level, voltage, overcharge_alert, fault_clear,
    input  charge_en, current_sel, state, charge_done, fault, fault_code
  );
endinterface

// File: rtl/charge_stage_sequencer.sv
// Multi-stage charge sequencer: trickle (PRE), bulk (constant current) and taper (constant
// voltage), with a DONE hold and a latched FAULT state.
// Compile-time option STAGE_TIMEOUT_EN builds the per-stage timer and the timeout fault
// (code 10); without it no timer exists and timeout never fires.
module charge_stage_sequencer #(
  parameter logic [7:0]  LOW_LEVEL      = 8'd20,
  parameter logic [7:0]  HEALTHY_LEVEL  = 8'd80,
  parameter logic [7:0]  FULL_LEVEL     = 8'd100,
  parameter logic [7:0]  CV_VOLTAGE     = 8'd240,
  parameter logic [7:0]  RECHARGE_LEVEL = 8'd95,
  parameter int unsigned FULL_HOLD      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned TMR_W          = 16
) (
  input logic                     clk_i,
  input logic                     reset_i,
  charge_stage_sequencer_if.slave bus_io
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPre   = 3'd1,
    StBulk  = 3'd2,
    StTaper = 3'd3,
    StDone  = 3'd4,
    StFault = 3'd5
  } state_e;

  localparam int unsigned HoldW = (FULL_HOLD > 1) ? $clog2(FULL_HOLD) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(FULL_HOLD - 1);

  localparam logic [1:0] CodeNone   = 2'b00;
  localparam logic [1:0] CodeOver   = 2'b01;
  localparam logic [1:0] CodeTime   = 2'b10;
  localparam logic [1:0] CodeSensor = 2'b11;

  state_e           state_q, state_d;
  logic [1:0]       code_q, code_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             timeout;

  logic       charge_en_q, charge_en_d;
  logic [1:0] current_sel_q, current_sel_d;
  logic       charge_done_q, charge_done_d;
  logic       fault_q, fault_d;

  // Stage chosen when charging (re)starts, based purely on the present level.
  function automatic state_e entry_sel(logic [7:0] lvl);
    if (lvl < LOW_LEVEL) begin
      return StPre;
    end else if (lvl < HEALTHY_LEVEL) begin
      return StBulk;
    end else if (lvl < FULL_LEVEL) begin
      return StTaper;
    end
    return StDone;
  endfunction

`ifdef STAGE_TIMEOUT_EN
  localparam logic [TMR_W-1:0] TmrLast = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TmrMax  = '1;

  logic [TMR_W-1:0] tmr_q, tmr_d;

  // Stage timer next value: restart on any state change, count (saturating) while charging.
  always_comb begin
    tmr_d = tmr_q;
    if (state_d != state_q) begin
      tmr_d = '0;
    end else if ((state_q == StPre || state_q == StBulk || state_q == StTaper) &&
                 (tmr_q != TmrMax)) begin
      tmr_d = tmr_q + 1'b1;
    end
  end

  // Stage timer register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end

  assign timeout = (tmr_q == TmrLast);
`else
  logic [TMR_W-1:0] unused_tmr_cfg;
  assign unused_tmr_cfg = TMR_W'(TIMEOUT_CYCLES);
  assign timeout        = 1'b0;
`endif

  // Next-state, fault code and taper hold counter.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    hold_d  = '0;
    case (state_q)
      StIdle: begin
        if (bus_io.overcharge_alert) begin
          state_d = StFault;
          code_d  = CodeOver;
        end else if (bus_io.start && !bus_io.stop) begin
          state_d = entry_sel(bus_io.battery_level);
        end
      end
      StPre, StBulk, StTaper, StDone: begin
        if (bus_io.overcharge_alert) begin
          state_d = StFault;
          code_d  = CodeOver;
        end else if (bus_io.battery_level > FULL_LEVEL) begin
          state_d = StFault;
          code_d  = CodeSensor;
        end else if (bus_io.stop) begin
          state_d = StIdle;
        end else if (timeout && (state_q != StDone)) begin
          state_d = StFault;
          code_d  = CodeTime;
        end else if (state_q == StPre) begin
          if (bus_io.battery_level >= LOW_LEVEL) state_d = StBulk;
        end else if (state_q == StBulk) begin
          if ((bus_io.battery_level >= HEALTHY_LEVEL) || (bus_io.voltage >= CV_VOLTAGE)) begin
            state_d = StTaper;
          end
        end else if (state_q == StTaper) begin
          // Count consecutive full cycles; the FULL_HOLD-th one completes the charge.
          if (bus_io.battery_level == FULL_LEVEL) begin
            if (hold_q == HoldLast) begin
              state_d = StDone;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end else begin
          if (bus_io.battery_level < RECHARGE_LEVEL) begin
            state_d = entry_sel(bus_io.battery_level);
          end
        end
      end
      StFault: begin
        if (bus_io.fault_clear && !bus_io.overcharge_alert) begin
          state_d = StIdle;
          code_d  = CodeNone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode from the next state so outputs change on the same edge as state.
  always_comb begin
    charge_en_d   = 1'b0;
    current_sel_d = 2'b00;
    charge_done_d = 1'b0;
    fault_d       = 1'b0;
    case (state_d)
      StPre: begin
        charge_en_d   = 1'b1;
        current_sel_d = 2'b01;
      end
      StBulk: begin
        charge_en_d   = 1'b1;
        current_sel_d = 2'b10;
      end
      StTaper: begin
        charge_en_d   = 1'b1;
        current_sel_d = 2'b11;
      end
      StDone:  charge_done_d = 1'b1;
      StFault: fault_d = 1'b1;
      default: ;
    endcase
  end

  // State, code, hold counter and registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      code_q        <= CodeNone;
      hold_q        <= '0;
      charge_en_q   <= 1'b0;
      current_sel_q <= 2'b00;
      charge_done_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      code_q        <= code_d;
      hold_q        <= hold_d;
      charge_en_q   <= charge_en_d;
      current_sel_q <= current_sel_d;
      charge_done_q <= charge_done_d;
      fault_q       <= fault_d;
    end
  end

  assign bus_io.state       = state_q;
  assign bus_io.fault_code  = code_q;
  assign bus_io.charge_en   = charge_en_q;
  assign bus_io.current_sel = current_sel_q;
  assign bus_io.charge_done = charge_done_q;
  assign bus_io.fault       = fault_q;

endmodule

// File: doc/charge_stage_sequencer.md
Name: charge_stage_sequencer

Overview:
- Multi-stage charge controller: sequences trickle (precharge), bulk (constant current) and taper (constant voltage) stages from the measured battery level and voltage.
- Drives the charger enable and current-select, and enters a latched fault state on overcharge, sensor error or stage timeout.
- Sits between the battery health monitor (consumes its overcharge_alert) and the charger power stage.

Parameters:
LOW_LEVEL, 8'd20, level below which trickle charge is used
HEALTHY_LEVEL, 8'd80, level at which bulk hands over to taper
FULL_LEVEL, 8'd100, full-charge level
CV_VOLTAGE, 8'd240, voltage at or above which bulk hands over to taper regardless of level
RECHARGE_LEVEL, 8'd95, level below which DONE restarts charging
FULL_HOLD, 16, consecutive cycles at FULL_LEVEL required in TAPER before DONE
TIMEOUT_CYCLES, 1000, maximum cycles allowed in any one charging stage
TMR_W, 16, stage timer width; must satisfy 2^TMR_W > TIMEOUT_CYCLES

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  request to begin charging; sampled in IDLE only
stop  input  1  abort charging and return to IDLE
battery_level  input  8  battery level in percent (0-100 valid)
voltage  input  8  battery voltage
overcharge_alert  input  1  overcharge flag from the health monitor
fault_clear  input  1  acknowledge and clear a fault
charge_en  output  1  charger enable
current_sel  output  2  00 off, 01 trickle, 10 bulk, 11 taper
state  output  3  current state encoding
charge_done  output  1  high while in DONE
fault  output  1  high while in FAULT
fault_code  output  2  00 none, 01 overcharge, 10 timeout, 11 sensor (level > FULL_LEVEL)

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset effect: state becomes IDLE; all outputs 0; stage timer and hold counter 0. Reset asserted mid-stage takes effect at the next edge.
- State encoding: IDLE=0, PRE=1, BULK=2, TAPER=3, DONE=4, FAULT=5. Codes 6 and 7 are illegal and go to IDLE on the next edge.
- Output timing: all outputs are registered and update on the same edge as state, so they are decoded from the next state.
- Output decode by state:
  - IDLE: charge_en=0, current_sel=00.
  - PRE: charge_en=1, current_sel=01.
  - BULK: charge_en=1, current_sel=10.
  - TAPER: charge_en=1, current_sel=11.
  - DONE: charge_en=0, current_sel=00, charge_done=1.
  - FAULT: charge_en=0, current_sel=00, fault=1.
- Entry selection (used from IDLE on start, and from DONE on restart):
  - level < LOW_LEVEL -> PRE.
  - level < HEALTHY_LEVEL -> BULK.
  - level < FULL_LEVEL -> TAPER.
  - otherwise -> DONE (IDLE only).
- Per-cycle priority in PRE, BULK, TAPER and DONE, highest first:
  1. overcharge_alert -> FAULT, code 01.
  2. battery_level > FULL_LEVEL -> FAULT, code 11.
  3. stop -> IDLE.
  4. stage timeout (not applied in DONE) -> FAULT, code 10.
  5. normal transition.
- Normal transitions:
  - IDLE: start && !stop -> entry selection. overcharge_alert in IDLE -> FAULT, code 01.
  - PRE: level >= LOW_LEVEL -> BULK.
  - BULK: level >= HEALTHY_LEVEL || voltage >= CV_VOLTAGE -> TAPER.
  - TAPER: hold counter increments while level == FULL_LEVEL and clears to 0 otherwise. When it reaches FULL_HOLD-1 with level still FULL_LEVEL -> DONE, i.e. after exactly FULL_HOLD consecutive full cycles.
  - DONE: level < RECHARGE_LEVEL -> entry selection (no start needed). start is ignored in DONE.
  - FAULT: fault_clear && !overcharge_alert -> IDLE; fault_code is cleared on that edge. fault_code is otherwise held. fault_clear while overcharge_alert is high is ignored.
- Stage timer:
  - Cleared on every state change; increments each cycle in PRE, BULK or TAPER; saturates and never wraps.
  - Timeout fires when the timer equals TIMEOUT_CYCLES-1, so FAULT is entered after exactly TIMEOUT_CYCLES cycles in one stage.
  - If timeout and a normal transition coincide, timeout wins.
- Simultaneous start and stop in IDLE: stay in IDLE.

Optional Feature:
STAGE_TIMEOUT_EN
- Defined: stage timer and timeout fault (code 10) are implemented as described above.
- Undefined: no stage timer logic is built, timeout never fires, and fault_code 10 is unreachable. All other behaviour is identical.

Test Plan:
- Reset, level=10, start pulse -> PRE, current_sel=01, charge_en=1. Ramp level to 20 -> BULK/10. Ramp to 80 -> TAPER/11. Hold 100 for 16 cycles -> DONE, charge_done=1 on the 16th edge, charge_en=0.
- In BULK at level=50, voltage=240 -> TAPER next edge. Voltage=239 for 10 cycles -> stays BULK.
- In TAPER, level=100 for 15 cycles, 99 for 1 cycle, then 100 -> hold restarts; DONE only after 16 more full cycles. In DONE, level 94 -> TAPER with no start.
- In BULK, assert overcharge_alert and stop in the same cycle -> FAULT, fault_code=01. fault_clear while alert high -> stays FAULT. Drop alert, then fault_clear -> IDLE, fault_code=00.
- With STAGE_TIMEOUT_EN, level held at 10 in PRE -> FAULT, code 10, after exactly 1000 cycles. Without the macro -> stays PRE.
- In TAPER, level=101 -> FAULT, code 11. Assert reset mid-BULK -> IDLE with all outputs 0 on the next edge.
